// File: rtl/zp_seq_if.sv
// zp_seq_if: config, job-control, upstream and subtract-stage signals of zp_seq.
interface zp_seq_if #(
    parameter int DEPTH = 16,
    parameter int LEN_W = 16
);
    localparam int AW = $clog2(DEPTH);
    logic              cfg_we_i;
    logic [AW-1:0]     cfg_addr_i;
    logic [31:0]       cfg_zp_i;
    logic              start_i;
    logic [AW:0]       num_tiles_i;
    logic [LEN_W-1:0]  tile_len_i;
    logic              busy_o;
    logic              done_o;
    logic              in_valid_i;
    logic [31:0]       in_data_i;
    logic              in_ready_o;
    logic [31:0]       zp_o;
    logic              zp_valid_o;
    logic              data_valid_o;
    logic [31:0]       data_o;
    logic [AW-1:0]     tile_idx_o;

    modport master (
        output cfg_we_i, cfg_addr_i, cfg_zp_i, start_i, num_tiles_i, tile_len_i, in_valid_i, in_data_i,
        input  busy_o, done_o, in_ready_o, zp_o, zp_valid_o, data_valid_o, data_o, tile_idx_o
    );
    modport slave (
        input  cfg_we_i, cfg_addr_i, cfg_zp_i, start_i, num_tiles_i, tile_len_i, in_valid_i, in_data_i,
        output busy_o, done_o, in_ready_o, zp_o, zp_valid_o, data_valid_o, data_o, tile_idx_o
    );
endinterface

// File: rtl/zp_seq.sv
// zp_seq: walks a job of tiles, loading each tile's zero-point from a small table
// before streaming that tile's accumulator beats to the subtract stage.
module zp_seq #(
    parameter int DEPTH = 16,
    parameter int LEN_W = 16
) (
    input logic     clk_i,
    input logic     rst_i,
    zp_seq_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, STREAM = 3'd2, GAP = 3'd3, DONE = 3'd4;

    logic [2:0]       state;
    logic [31:0]      zp_tab [DEPTH];
    logic [AW:0]      ntiles;
    logic [LEN_W-1:0] len;
    logic [AW-1:0]    tile_idx;
    logic [LEN_W:0]   beat_cnt;
    logic [31:0]      zp_q, data_q;
    logic             dv_q;
    logic             accept, cfg_ok, last_beat, last_tile;

    assign accept    = (state == STREAM) && bus.in_valid_i;
    assign cfg_ok    = bus.cfg_we_i && (state == IDLE);
    assign last_beat = (beat_cnt + 1'b1) == {1'b0, len};
    assign last_tile = ({1'b0, tile_idx} + 1'b1) == ntiles;

    assign bus.busy_o       = state != IDLE;
    assign bus.done_o       = state == DONE;
    assign bus.in_ready_o   = state == STREAM;
    assign bus.zp_valid_o   = state == LOAD;
    assign bus.zp_o         = zp_q;
    assign bus.data_valid_o = dv_q;
    assign bus.data_o       = data_q;
    assign bus.tile_idx_o   = tile_idx;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            for (int i = 0; i < DEPTH; i++) zp_tab[i] <= '0;
            ntiles   <= '0;
            len      <= '0;
            tile_idx <= '0;
            beat_cnt <= '0;
            zp_q     <= '0;
            data_q   <= '0;
            dv_q     <= 1'b0;
        end else begin
            if (cfg_ok) zp_tab[bus.cfg_addr_i] <= bus.cfg_zp_i;
            dv_q <= accept;
            if (accept) data_q <= bus.in_data_i;
            case (state)
                IDLE: if (bus.start_i) begin
                    ntiles   <= (bus.num_tiles_i > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.num_tiles_i;
                    len      <= bus.tile_len_i;
                    tile_idx <= '0;
                    beat_cnt <= '0;
                    // forward a same-cycle write to entry 0 so the first LOAD sees it
                    zp_q     <= (cfg_ok && bus.cfg_addr_i == '0) ? bus.cfg_zp_i : zp_tab[0];
                    state    <= (bus.num_tiles_i == '0 || bus.tile_len_i == '0) ? DONE : LOAD;
                end
                LOAD: state <= STREAM;
                STREAM: if (accept) begin
                    if (last_beat) begin
                        beat_cnt <= '0;
                        if (last_tile) state <= DONE;
                        else begin
                            state    <= GAP;
                            tile_idx <= tile_idx + 1'b1;
                        end
                    end else beat_cnt <= beat_cnt + 1'b1;
                end
                GAP: begin
                    zp_q  <= zp_tab[tile_idx];
                    state <= LOAD;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_zp_seq.sv
// tb_zp_seq: directed jobs against zp_seq with hand-computed per-cycle output masks.
module tb_zp_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    zp_seq_if #(.DEPTH(16), .LEN_W(16)) bus ();
    zp_seq #(.DEPTH(16), .LEN_W(16)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int total = 0;
    int bad = 0;
    logic [63:0] zpv_m, dv_m, done_m, rdy_m;
    logic [31:0] zps[$], dat[$], tix[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_q(input string tag, input logic [31:0] q[$], input logic [31:0] e[$]);
        check({tag, "_n"}, 64'(q.size()), 64'(e.size()));
        for (int i = 0; i < e.size(); i++)
            check($sformatf("%s_%0d", tag, i), (i < q.size()) ? q[i] : 32'hDEADBEEF, e[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int a, input logic [31:0] v);
        bus.cfg_we_i = 1'b1;
        bus.cfg_addr_i = 4'(a);
        bus.cfg_zp_i = v;
        tick();
        bus.cfg_we_i = 1'b0;
    endtask

    task automatic outs_zero(input string tag);
        check(tag, {bus.busy_o, bus.done_o, bus.in_ready_o, bus.zp_valid_o, bus.data_valid_o,
                    bus.zp_o, bus.data_o, bus.tile_idx_o}, 0);
    endtask

    // cycle 0 carries start_i; bit i of each mask is the output in cycle i
    task automatic run(input int num, input int len, input bit tog, input int n,
                       input bit wr, input int wa, input logic [31:0] wv, input bit meddle);
        zpv_m = 0; dv_m = 0; done_m = 0; rdy_m = 0;
        zps.delete(); dat.delete(); tix.delete();
        bus.start_i = 1'b1;
        bus.num_tiles_i = 5'(num);
        bus.tile_len_i = 16'(len);
        bus.cfg_we_i = wr;
        bus.cfg_addr_i = 4'(wa);
        bus.cfg_zp_i = wv;
        bus.in_valid_i = !tog;
        bus.in_data_i = 32'd100;
        for (int i = 1; i <= n; i++) begin
            tick();
            bus.start_i = 1'b0;
            bus.cfg_we_i = 1'b0;
            zpv_m[i] = bus.zp_valid_o;
            dv_m[i] = bus.data_valid_o;
            done_m[i] = bus.done_o;
            rdy_m[i] = bus.in_ready_o;
            if (bus.zp_valid_o) begin
                zps.push_back(bus.zp_o);
                tix.push_back(32'(bus.tile_idx_o));
            end
            if (bus.data_valid_o) dat.push_back(bus.data_o);
            bus.in_valid_i = tog ? i[0] : 1'b1;
            bus.in_data_i = 32'(100 + i);
            if (meddle && i == 3) begin
                bus.cfg_we_i = 1'b1;
                bus.cfg_addr_i = 4'd0;
                bus.cfg_zp_i = 32'd99;
                bus.start_i = 1'b1;
                bus.num_tiles_i = 5'd1;
                bus.tile_len_i = 16'd1;
            end
        end
        bus.start_i = 1'b0;
        bus.cfg_we_i = 1'b0;
        bus.in_valid_i = 1'b0;
    endtask

    initial begin
        logic [31:0] e[$];
        bus.cfg_we_i = 0; bus.cfg_addr_i = 0; bus.cfg_zp_i = 0; bus.start_i = 0;
        bus.num_tiles_i = 0; bus.tile_len_i = 0; bus.in_valid_i = 0; bus.in_data_i = 0;
        tick();
        tick();
        outs_zero("reset");
        rst = 1'b0;
        cfg(0, 32'd5);
        cfg(1, -32'sd3);

        run(2, 3, 0, 14, 0, 0, 0, 0);
        check("two_zpv", zpv_m, 64'h0042);
        check("two_dv", dv_m, 64'h0738);
        check("two_done", done_m, 64'h0400);
        check("two_rdy", rdy_m, 64'h039C);
        e = '{32'd5, 32'hFFFFFFFD}; check_q("two_zp", zps, e);
        e = '{32'd102, 32'd103, 32'd104, 32'd107, 32'd108, 32'd109}; check_q("two_data", dat, e);
        e = '{32'd0, 32'd1}; check_q("two_tix", tix, e);
        check("idx_hold", bus.tile_idx_o, 1);

        run(1, 4, 1, 14, 0, 0, 0, 0);
        check("tog_zpv", zpv_m, 64'h0002);
        check("tog_dv", dv_m, 64'h0550);
        check("tog_done", done_m, 64'h0400);
        check("tog_rdy", rdy_m, 64'h03FC);
        e = '{32'd103, 32'd105, 32'd107, 32'd109}; check_q("tog_data", dat, e);

        run(0, 5, 0, 4, 0, 0, 0, 0);
        check("zero_done", done_m, 64'h0002);
        check("zero_other", zpv_m | dv_m | rdy_m, 0);

        run(2, 3, 0, 14, 0, 0, 0, 1);
        check("busy_zpv", zpv_m, 64'h0042);
        check("busy_dv", dv_m, 64'h0738);
        check("busy_done", done_m, 64'h0400);
        e = '{32'd5, 32'hFFFFFFFD}; check_q("busy_zp", zps, e);

        run(1, 1, 0, 5, 0, 0, 0, 0);
        check("old_dv", dv_m, 64'h0008);
        check("old_done", done_m, 64'h0008);
        e = '{32'd5}; check_q("old_zp", zps, e);

        run(1, 1, 0, 5, 1, 0, 32'd7, 0);
        e = '{32'd7}; check_q("wr_start_zp", zps, e);

        run(2, 3, 0, 3, 0, 0, 0, 0);
        check("mid_rdy", bus.in_ready_o, 1);
        rst = 1'b1;
        tick();
        outs_zero("mid_reset");
        rst = 1'b0;
        run(2, 1, 0, 8, 1, 1, 32'd11, 0);
        check("post_zpv", zpv_m, 64'h0012);
        check("post_dv", dv_m, 64'h0048);
        check("post_done", done_m, 64'h0040);
        check("post_rdy", rdy_m, 64'h0024);
        e = '{32'd0, 32'd11}; check_q("post_zp", zps, e);

        run(20, 1, 0, 52, 0, 0, 0, 0);
        check("clamp_zpv_n", 64'($countones(zpv_m)), 16);
        check("clamp_dv_n", 64'($countones(dv_m)), 16);
        check("clamp_done", done_m, 64'h1 << 48);
        e.delete();
        for (int i = 0; i < 16; i++) e.push_back(32'(i));
        check_q("clamp_tix", tix, e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
